// File: rtl/cordic_calc_stream.sv
// ---------------------------------------------------------------------------
// cordic_calc_stream
//   Streaming multi-mode CORDIC calculator. Requests enter via valid/ready into
//   a small FIFO, one iterative engine performs one micro-rotation per clock,
//   a single post-scale step selects/scales the result, and the result leaves
//   through a tagged valid/ready port. Signed fixed point with FRAC fractional
//   bits; angles in radians.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready = queue not full)
//   in_op              0 SIN 1 COS 2 ATAN 3 MOD 4 MULT 5 DIV 6 SINH 7 COSH
//                      8 ATANH 9 MODH (10..15 unsupported -> error result)
//   in_x/in_y/in_z     signed operands
//   in_tag             user tag, returned with the result
//   out_valid/ready    result handshake; outputs held while stalled
//   out_result         signed primary result
//   out_tag            tag of the request that produced out_result
//   out_err            unsupported op or DIV by zero (out_result = 0)
//   busy               engine active or queue non-empty
// ---------------------------------------------------------------------------
module cordic_calc_stream #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int ITERATIONS = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IT_W  = $clog2(ITERATIONS + 1);
    localparam int SH_W  = $clog2(ITERATIONS + 2);

    localparam logic [3:0] OP_SIN  = 4'd0, OP_COS   = 4'd1, OP_ATAN  = 4'd2,
                           OP_MOD  = 4'd3, OP_MULT  = 4'd4, OP_DIV   = 4'd5,
                           OP_SINH = 4'd6, OP_COSH  = 4'd7, OP_ATANH = 4'd8,
                           OP_MODH = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_OUT} state_t;

    // Constants are written in Q16.16 and rescaled to the FRAC in use.
    function automatic logic signed [WIDTH-1:0] q16(input longint c);
        longint v;
        if (FRAC >= 16) v = c <<< (FRAC - 16);
        else            v = c >>> (16 - FRAC);
        return WIDTH'(v);
    endfunction

    // atan(2^-i); beyond i=6 the angle equals 2^-i at this precision.
    function automatic logic signed [WIDTH-1:0] atan_step(input logic [SH_W-1:0] i);
        longint c;
        if (i >= SH_W'(7)) c = 64'sd65536 >>> i;
        else begin
            case (int'(i))
                0:       c = 51472;
                1:       c = 30386;
                2:       c = 16055;
                3:       c = 8150;
                4:       c = 4091;
                5:       c = 2047;
                default: c = 1024;
            endcase
        end
        return q16(c);
    endfunction

    // atanh(2^-i), i >= 1.
    function automatic logic signed [WIDTH-1:0] atanh_step(input logic [SH_W-1:0] i);
        longint c;
        if (i >= SH_W'(7)) c = 64'sd65536 >>> i;
        else begin
            case (int'(i))
                1:       c = 35999;
                2:       c = 16739;
                3:       c = 8235;
                4:       c = 4101;
                5:       c = 2049;
                6:       c = 1024;
                default: c = 0;
            endcase
        end
        return q16(c);
    endfunction

    // a*k with FRAC-bit renormalisation, saturated to WIDTH signed.
    function automatic logic signed [WIDTH-1:0] scale_sat(input logic signed [WIDTH-1:0] a,
                                                          input logic signed [WIDTH-1:0] k);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(k);
        p = p >>> FRAC;
        if (p[2*WIDTH-1:WIDTH-1] == '0 || p[2*WIDTH-1:WIDTH-1] == '1)
            return p[WIDTH-1:0];
        else if (p[2*WIDTH-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    localparam logic signed [WIDTH-1:0] INV_K   = q16(64'sd39797);   // 0.6072529
    localparam logic signed [WIDTH-1:0] INV_KH  = q16(64'sd79135);   // 1.2074970
    localparam logic signed [WIDTH-1:0] PI      = q16(64'sd205887);
    localparam logic signed [WIDTH-1:0] HALF_PI = q16(64'sd102944);
    localparam logic signed [WIDTH-1:0] ONE     = q16(64'sd65536);

    // ---------------- request FIFO ----------------
    logic [3:0]       q_op  [FIFO_DEPTH];
    logic [WIDTH-1:0] q_x   [FIFO_DEPTH];
    logic [WIDTH-1:0] q_y   [FIFO_DEPTH];
    logic [WIDTH-1:0] q_z   [FIFO_DEPTH];
    logic [TAG_W-1:0] q_tag [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    state_t           state;

    assign in_ready = !rst && (count != CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && ((state == S_IDLE) || (state == S_OUT && out_ready));
    assign busy     = (state != S_IDLE) || (count != '0);

    // NOTE: FIFO storage is not reset; only pointers and count define validity,
    // so clearing the array would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]  <= in_op;
            q_x[wr_ptr]   <= in_x;
            q_y[wr_ptr]   <= in_y;
            q_z[wr_ptr]   <= in_z;
            q_tag[wr_ptr] <= in_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- operand preparation at pop ----------------
    logic [3:0]              h_op;
    logic signed [WIDTH-1:0] h_x, h_y, h_z;
    logic signed [WIDTH-1:0] ld_x, ld_y, ld_z;
    logic                    ld_neg, ld_err, ld_hyp;

    assign h_op   = q_op[rd_ptr];
    assign h_x    = q_x[rd_ptr];
    assign h_y    = q_y[rd_ptr];
    assign h_z    = q_z[rd_ptr];
    assign ld_hyp = (h_op >= OP_SINH) && (h_op <= OP_MODH);

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        ld_x   = h_x;
        ld_y   = h_y;
        ld_z   = '0;
        ld_neg = 1'b0;
        ld_err = (h_op > OP_MODH) || (h_op == OP_DIV && h_x == '0);
        case (h_op)
            OP_SIN, OP_COS: begin
                ld_x = INV_K;
                ld_y = '0;
                ld_z = h_z;
                // Fold into [-pi/2, pi/2]; sin/cos flip sign under a pi shift.
                if (h_z > HALF_PI) begin
                    ld_z   = h_z - PI;
                    ld_neg = 1'b1;
                end else if (h_z < -HALF_PI) begin
                    ld_z   = h_z + PI;
                    ld_neg = 1'b1;
                end
            end
            OP_SINH, OP_COSH: begin
                ld_x = INV_KH;
                ld_y = '0;
                ld_z = h_z;
            end
            OP_ATAN, OP_MOD: begin
                // Left half-plane: rotate by pi so vectoring converges.
                if (h_x < 0) begin
                    ld_x = -h_x;
                    ld_y = -h_y;
                    ld_z = (h_y >= 0) ? PI : -PI;
                end
            end
            OP_MULT: begin
                ld_y = '0;
                ld_z = h_z;
            end
            default: ;
        endcase
    end

    // ---------------- iteration datapath ----------------
    logic signed [WIDTH-1:0] x_r, y_r, z_r;
    logic signed [WIDTH-1:0] x_n, y_n, z_n, x_sh, y_sh, step, res;
    logic [3:0]              op_r;
    logic [TAG_W-1:0]        tag_r;
    logic                    neg_r, err_r, rep;
    logic [IT_W-1:0]         cnt;
    logic [SH_W-1:0]         sh;
    logic                    is_hyp, is_lin, is_vec, d_pos;

    assign is_hyp = (op_r >= OP_SINH) && (op_r <= OP_MODH);
    assign is_lin = (op_r == OP_MULT) || (op_r == OP_DIV);
    assign is_vec = (op_r == OP_ATAN) || (op_r == OP_MOD) || (op_r == OP_DIV) ||
                    (op_r == OP_ATANH) || (op_r == OP_MODH);
    // d = +1 when d_pos: rotation follows sign(z), vectoring drives y to zero.
    assign d_pos  = is_vec ? y_r[WIDTH-1] : !z_r[WIDTH-1];

    always_comb begin
        x_sh = x_r >>> sh;
        y_sh = y_r >>> sh;
        if (is_lin)      step = ONE >>> sh;
        else if (is_hyp) step = atanh_step(sh);
        else             step = atan_step(sh);
        if (is_lin)      x_n = x_r;
        else if (is_hyp) x_n = d_pos ? x_r + y_sh : x_r - y_sh;
        else             x_n = d_pos ? x_r - y_sh : x_r + y_sh;
        y_n = d_pos ? y_r + x_sh : y_r - x_sh;
        z_n = d_pos ? z_r - step : z_r + step;
    end

    always_comb begin
        case (op_r)
            OP_SIN:           res = neg_r ? -y_r : y_r;
            OP_COS:           res = neg_r ? -x_r : x_r;
            OP_SINH, OP_MULT: res = y_r;
            OP_COSH:          res = x_r;
            OP_MOD:           res = scale_sat(x_r, INV_K);
            OP_MODH:          res = scale_sat(x_r, INV_KH);
            default:          res = z_r;
        endcase
        if (err_r) res = '0;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
            op_r       <= '0;
            tag_r      <= '0;
            neg_r      <= 1'b0;
            err_r      <= 1'b0;
            rep        <= 1'b0;
            cnt        <= '0;
            sh         <= '0;
        end else begin
            case (state)
                S_ITER: begin
                    x_r <= x_n;
                    y_r <= y_n;
                    z_r <= z_n;
                    cnt <= cnt + 1'b1;
                    // Hyperbolic steps 4 and 13 run twice for convergence.
                    if (is_hyp && !rep && (sh == SH_W'(4) || sh == SH_W'(13))) begin
                        rep <= 1'b1;
                    end else begin
                        rep <= 1'b0;
                        sh  <= sh + 1'b1;
                    end
                    if (cnt == IT_W'(ITERATIONS - 1)) state <= S_SCALE;
                end
                S_SCALE: begin
                    out_result <= res;
                    out_tag    <= tag_r;
                    out_err    <= err_r;
                    out_valid  <= 1'b1;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: ;
            endcase
            // A pop (from IDLE, or on the OUT handshake edge) starts the next op.
            if (pop) begin
                x_r   <= ld_x;
                y_r   <= ld_y;
                z_r   <= ld_z;
                op_r  <= h_op;
                tag_r <= q_tag[rd_ptr];
                neg_r <= ld_neg;
                err_r <= ld_err;
                cnt   <= '0;
                rep   <= 1'b0;
                sh    <= ld_hyp ? SH_W'(1) : '0;
                state <= ld_err ? S_SCALE : S_ITER;
            end
        end
    end

endmodule

// File: tb/tb_cordic_calc_stream.sv
// ---------------------------------------------------------------------------
// tb_cordic_calc_stream
//   Directed-vector bench for cordic_calc_stream. The stimulus process pushes
//   hand-computed expected results into a scoreboard queue on each accepted
//   request; an independent monitor pops and compares whenever a result is
//   handed over (out_valid & out_ready).
// ---------------------------------------------------------------------------
module tb_cordic_calc_stream;

    localparam int  TOL = 64;          // 2^-10 in Q16.16

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_x, in_y, in_z;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;

    cordic_calc_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_z       (in_z),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tag;
        longint     res;
        logic       err;
        longint     tol;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_tol(input string name, input longint got, input longint want,
                             input longint tol);
        longint diff;
        n_cmp++;
        diff = got - want;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d +/- %0d", name, got, want, tol);
        end
    endtask

    // Monitor: compares each handed-over result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got tag %0d result %0d, required no result",
                         out_tag, $signed(out_result));
            end else begin
                e = sb.pop_front();
                check($sformatf("tag_for_%0d", e.tag), longint'(out_tag), longint'(e.tag));
                check($sformatf("err_tag%0d", e.tag), longint'(out_err), longint'(e.err));
                check_tol($sformatf("result_tag%0d", e.tag), longint'($signed(out_result)),
                          e.res, e.tol);
            end
        end
    end

    // Issue one request; the expected response is queued on the accept edge.
    task automatic send(input logic [3:0] op, input int x, input int y, input int z,
                        input logic [3:0] tag, input int exp_res, input logic exp_err);
        bit   ok;
        exp_t e;
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_tag   = tag;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        check($sformatf("accept_tag%0d", tag), longint'(ok), 1);
        if (ok) begin
            e.tag = tag;
            e.res = longint'(exp_res);
            e.err = exp_err;
            e.tol = exp_err ? 0 : TOL;
            sb.push_back(e);
        end
    endtask

    // Edges from now until out_valid is seen (sampled #1 after each edge).
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", longint'(sb.size()), 0);
        check("drain_busy", longint'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_out_result", longint'(out_result), 0);
        check("rst_out_tag", longint'(out_tag), 0);
        check("rst_out_err", longint'(out_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", longint'(in_ready), 1);

        // SIN(pi/6) with latency measurement on an idle engine.
        send(4'd0, 0, 0, 32'h0000_860A, 4'd3, 32'h0000_8000, 1'b0);
        wait_valid(lat);
        check("sin_latency", longint'(lat), 18);
        drain();

        // Mode coverage, back-to-back.
        send(4'd1, 0, 0, 32'h0003_243F, 4'd1, -65536, 1'b0);           // COS(pi)    = -1
        send(4'd2, -65536, 65536, 0, 4'd2, 154415, 1'b0);              // ATAN(-1,1) = 3pi/4
        send(4'd2, -65536, -65536, 0, 4'd4, -154415, 1'b0);            // ATAN(-1,-1)= -3pi/4
        send(4'd3, 196608, 262144, 0, 4'd5, 327680, 1'b0);             // magnitude of (3,4) = 5
        send(4'd5, 262144, 65536, 0, 4'd6, 16384, 1'b0);               // DIV 1/4    = 0.25
        send(4'd4, 196608, 0, -98304, 4'd7, -294912, 1'b0);            // MULT 3*-1.5= -4.5
        send(4'd0, 0, 0, -131072, 4'd8, -59592, 1'b0);                 // SIN(-2)
        send(4'd6, 0, 0, 32768, 4'd9, 34151, 1'b0);                    // SINH(0.5)
        send(4'd7, 0, 0, 32768, 4'd10, 73900, 1'b0);                   // COSH(0.5)
        send(4'd8, 65536, 32768, 0, 4'd11, 35999, 1'b0);               // ATANH(0.5)
        send(4'd9, 131072, 65536, 0, 4'd12, 113512, 1'b0);             // MODH(2,1)  = sqrt3
        send(4'd5, 0, 65536, 0, 4'd13, 0, 1'b1);                       // DIV by zero
        drain();

        // Unsupported op: error result two edges after accept.
        send(4'd12, 65536, 65536, 65536, 4'd14, 0, 1'b1);
        wait_valid(lat);
        check("err_latency", longint'(lat), 2);
        drain();

        // Back-pressure: queue fills, stalled output holds steady.
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int t = 0; t < 5; t++)
            send(4'd4, (t + 1) * 65536, 0, 32768, 4'(t), (t + 1) * 32768, 1'b0);
        check("full_in_ready", longint'(in_ready), 0);
        in_op    = 4'd4;
        in_x     = 32'h0001_0000;
        in_z     = 32'h0000_8000;
        in_tag   = 4'd5;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_valid", longint'(out_valid), 1);
            check("hold_tag", longint'(out_tag), 0);
            check("hold_err", longint'(out_err), 0);
            check_tol("hold_result", longint'($signed(out_result)), 32768, TOL);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset while iterating with two requests queued.
        send(4'd4, 65536, 0, 16384, 4'd7, 16384, 1'b0);
        send(4'd4, 65536, 0, 16384, 4'd8, 16384, 1'b0);
        send(4'd4, 65536, 0, 16384, 4'd9, 16384, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", longint'(busy), 1);
        sb.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_in_ready", longint'(in_ready), 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("no_stale_result", longint'(seen), 0);
        @(posedge clk);
        #1;
        send(4'd4, 131072, 0, 49152, 4'd10, 98304, 1'b0);              // 2 * 0.75
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
